// File: rtl/hex_display_scan_pkg.sv
// rtl/hex_display_scan_pkg.sv - shared seven-segment constants for the display scanner
package hex_display_scan_pkg;

  // Segment vectors are ordered gfedcba: bit 0 = a ... bit 6 = g
  localparam int SEG_A = 0;
  localparam int SEG_G = 6;
  localparam int SEG_W = SEG_G - SEG_A + 1;

  localparam logic [SEG_W-1:0] SEG_BLANK_L = 7'b1111111;

  // 1 ms per digit slot and 0.5 s blink half-period at 50 MHz
  localparam int DEFAULT_SCAN_DIV  = 50000;
  localparam int DEFAULT_BLINK_DIV = 25000000;

endpackage

// File: rtl/hex_display_scan_if.sv
// rtl/hex_display_scan_if.sv - load and display bus of the hex display scanner
interface hex_display_scan_if #(
  parameter int DIGITS = 6
);
  logic                  i_load;
  logic [4*DIGITS-1:0]   i_num;
  logic [DIGITS-1:0]     i_dp;
  logic [DIGITS-1:0]     i_blink;
  logic                  i_blank_lz;
  logic [6:0]            o_seg;
  logic                  o_dp;
  logic [DIGITS-1:0]     o_an;
  logic [7*DIGITS-1:0]   o_hex_flat;
  logic                  o_pending;

  modport master (
    output i_load, i_num, i_dp, i_blink, i_blank_lz,
    input  o_seg, o_dp, o_an, o_hex_flat, o_pending
  );

  modport slave (
    input  i_load, i_num, i_dp, i_blink, i_blank_lz,
    output o_seg, o_dp, o_an, o_hex_flat, o_pending
  );
endinterface

// File: rtl/clk_div_tick.sv
// rtl/clk_div_tick.sv - free-running 0..DIV-1 counter with a one-cycle terminal tick
module clk_div_tick #(
  parameter int DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign o_tick = (cnt_q == CNT_W'(DIV - 1));

  always_comb begin
    cnt_d = o_tick ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/hex_decoder.sv
// rtl/hex_decoder.sv - nibble to active-low gfedcba segment pattern
module hex_decoder
  import hex_display_scan_pkg::*;
(
  input  logic [3:0]       i_hex,
  output logic [SEG_W-1:0] o_seg_l
);

  always_comb begin
    o_seg_l = SEG_BLANK_L;
    case (i_hex)
      4'h0: o_seg_l = 7'b1000000;
      4'h1: o_seg_l = 7'b1111001;
      4'h2: o_seg_l = 7'b0100100;
      4'h3: o_seg_l = 7'b0110000;
      4'h4: o_seg_l = 7'b0011001;
      4'h5: o_seg_l = 7'b0010010;
      4'h6: o_seg_l = 7'b0000010;
      4'h7: o_seg_l = 7'b1111000;
      4'h8: o_seg_l = 7'b0000000;
      4'h9: o_seg_l = 7'b0010000;
      4'hA: o_seg_l = 7'b0001000;
      4'hB: o_seg_l = 7'b0000011;
      4'hC: o_seg_l = 7'b1000110;
      4'hD: o_seg_l = 7'b0100001;
      4'hE: o_seg_l = 7'b0000110;
      4'hF: o_seg_l = 7'b0001110;
      default: o_seg_l = SEG_BLANK_L;
    endcase
  end

endmodule

// File: rtl/hex_display_scan.sv
// rtl/hex_display_scan.sv - multiplexed and static seven-segment driver with
// frame-synchronous load, leading-zero blanking, blink and selectable polarity
module hex_display_scan
  import hex_display_scan_pkg::*;
#(
  parameter int DIGITS     = 6,
  parameter int SCAN_DIV   = DEFAULT_SCAN_DIV,
  parameter int BLINK_DIV  = DEFAULT_BLINK_DIV,
  parameter int ACTIVE_LOW = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  hex_display_scan_if.slave bus
);

  localparam int         IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [6:0] SEG_OFF = (ACTIVE_LOW != 0) ? SEG_BLANK_L : ~SEG_BLANK_L;
  localparam logic       ON_LVL  = (ACTIVE_LOW != 0) ? 1'b0 : 1'b1;

  logic [4*DIGITS-1:0] num_pend_q, num_pend_d, num_cmt_q, num_cmt_d;
  logic [DIGITS-1:0]   dp_pend_q, dp_pend_d, dp_cmt_q, dp_cmt_d;
  logic [DIGITS-1:0]   blink_pend_q, blink_pend_d, blink_cmt_q, blink_cmt_d;
  logic                pending_q, pending_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                phase_q, phase_d;
  logic                slot_tick, blink_tick, frame_end;

  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [7*DIGITS-1:0] flat_q, flat_d;

  logic [6:0]          dec_seg_l [DIGITS];
  logic                lz_run, blinked, hide;
  logic [6:0]          seg_l, seg_lvl;

  clk_div_tick #(.DIV(SCAN_DIV)) u_scan_div (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .o_tick (slot_tick)
  );

  clk_div_tick #(.DIV(BLINK_DIV)) u_blink_div (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .o_tick (blink_tick)
  );

  for (genvar g = 0; g < DIGITS; g++) begin : g_dec
    hex_decoder u_dec (
      .i_hex   (num_cmt_q[4*g +: 4]),
      .o_seg_l (dec_seg_l[g])
    );
  end

  assign frame_end = slot_tick && (idx_q == IDX_W'(DIGITS - 1));

  // Commit before capture so a load on the frame-end cycle keeps pending set
  always_comb begin
    num_pend_d   = num_pend_q;
    dp_pend_d    = dp_pend_q;
    blink_pend_d = blink_pend_q;
    num_cmt_d    = num_cmt_q;
    dp_cmt_d     = dp_cmt_q;
    blink_cmt_d  = blink_cmt_q;
    pending_d    = pending_q;
    if (frame_end && pending_q) begin
      num_cmt_d   = num_pend_q;
      dp_cmt_d    = dp_pend_q;
      blink_cmt_d = blink_pend_q;
      pending_d   = 1'b0;
    end
    if (bus.i_load) begin
      num_pend_d   = bus.i_num;
      dp_pend_d    = bus.i_dp;
      blink_pend_d = bus.i_blink;
      pending_d    = 1'b1;
    end
  end

  always_comb begin
    idx_d   = idx_q;
    phase_d = phase_q;
    if (slot_tick) idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    if (blink_tick) phase_d = ~phase_q;
  end

  // Walk from the most significant digit so lz_run means "all higher nibbles zero"
  always_comb begin
    lz_run  = 1'b1;
    blinked = 1'b0;
    hide    = 1'b0;
    seg_l   = SEG_BLANK_L;
    seg_lvl = SEG_OFF;
    seg_d   = SEG_OFF;
    dp_d    = ~ON_LVL;
    an_d    = {DIGITS{~ON_LVL}};
    flat_d  = {DIGITS{SEG_OFF}};
    for (int k = DIGITS - 1; k >= 0; k--) begin
      lz_run  = lz_run && (num_cmt_q[4*k +: 4] == 4'd0);
      blinked = phase_q && blink_cmt_q[k];
      hide    = blinked || ((k != 0) && bus.i_blank_lz && lz_run);
      seg_l   = hide ? SEG_BLANK_L : dec_seg_l[k];
      seg_lvl = (ACTIVE_LOW != 0) ? seg_l : ~seg_l;
      flat_d[7*k +: 7] = seg_lvl;
      if (idx_q == IDX_W'(k)) begin
        an_d[k] = ON_LVL;
        seg_d   = seg_lvl;
        dp_d    = (dp_cmt_q[k] && !blinked) ? ON_LVL : ~ON_LVL;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      num_pend_q   <= '0;
      dp_pend_q    <= '0;
      blink_pend_q <= '0;
      num_cmt_q    <= '0;
      dp_cmt_q     <= '0;
      blink_cmt_q  <= '0;
      pending_q    <= 1'b0;
      idx_q        <= '0;
      phase_q      <= 1'b0;
      seg_q        <= SEG_OFF;
      dp_q         <= ~ON_LVL;
      an_q         <= {DIGITS{~ON_LVL}};
      flat_q       <= {DIGITS{SEG_OFF}};
    end else begin
      num_pend_q   <= num_pend_d;
      dp_pend_q    <= dp_pend_d;
      blink_pend_q <= blink_pend_d;
      num_cmt_q    <= num_cmt_d;
      dp_cmt_q     <= dp_cmt_d;
      blink_cmt_q  <= blink_cmt_d;
      pending_q    <= pending_d;
      idx_q        <= idx_d;
      phase_q      <= phase_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      flat_q       <= flat_d;
    end
  end

  assign bus.o_seg      = seg_q;
  assign bus.o_dp       = dp_q;
  assign bus.o_an       = an_q;
  assign bus.o_hex_flat = flat_q;
  assign bus.o_pending  = pending_q;

endmodule
